// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction-fetch controller for the pipelined core.
//
// Owns the fetch PC and issues one request at a time to instruction memory
// over a req/gnt/rvalid bus. Returned words go into a two-entry queue
// (head + skid) that feeds decode. Absolute redirects from execute flush
// the queue and restart fetch at the target.
//
// Ports:
//   clk, rst_n              core clock, async active-low reset
//   redirect_en/addr        taken jump/branch pulse and absolute target
//   stall                   decode cannot accept the head this cycle
//   imem_req/addr           fetch request and word-aligned address
//   imem_gnt                request accepted this cycle
//   imem_rvalid/rdata       returned instruction (in order, one per grant)
//   if_valid/pc/instr       head entry toward decode (NOP when empty)
//
// Handshake: a memory request transfers on a cycle where imem_req and
// imem_gnt are both high; an ungranted request may be withdrawn or change
// address. Decode takes the head on a cycle where if_valid is high and
// stall is low.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_en,
  input  logic [31:0] redirect_addr,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        drop_q, drop_d;
  logic        head_valid_q, head_valid_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] head_instr_q, head_instr_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;

  logic [31:0] redirect_pc;
  logic        gnt_fire;
  logic        rsp_fire;
  logic        push;
  logic        consume;
  logic        unused_addr_bits;

  // Targets are word aligned by construction; the low bits carry no meaning.
  assign redirect_pc      = {redirect_addr[31:2], 2'b00};
  assign unused_addr_bits = ^redirect_addr[1:0];

  // Requests are held off while the skid is full so a response always has
  // somewhere to land. Depends only on flops: no path from stall or rvalid.
  assign imem_req  = (state_q == REQ) && !skid_valid_q;
  assign imem_addr = fetch_pc_q;

  assign gnt_fire = imem_req && imem_gnt;
  assign rsp_fire = (state_q == WAIT) && imem_rvalid;
  // A response belonging to a flushed path (drop) or arriving with a
  // redirect is discarded.
  assign push     = rsp_fire && !drop_q && !redirect_en;
  assign consume  = head_valid_q && !stall;

  // Fetch sequencing.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    drop_d     = drop_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (gnt_fire) begin
          state_d    = WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          // The request just granted is on the old path if we redirect now.
          drop_d     = redirect_en;
        end
      end
      WAIT: begin
        if (rsp_fire) begin
          state_d = REQ;
          drop_d  = 1'b0;
        end else if (redirect_en) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect_en) fetch_pc_d = redirect_pc;
  end

  // Head/skid queue: redirect flushes, otherwise consume and push share an edge.
  always_comb begin
    head_valid_d = head_valid_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if (redirect_en) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume) begin
      if (skid_valid_q) begin
        head_valid_d = 1'b1;
        head_pc_d    = skid_pc_q;
        head_instr_d = skid_instr_q;
        skid_valid_d = push;
        if (push) begin
          skid_pc_d    = req_pc_q;
          skid_instr_d = imem_rdata;
        end
      end else begin
        head_valid_d = push;
        if (push) begin
          head_pc_d    = req_pc_q;
          head_instr_d = imem_rdata;
        end
      end
    end else if (push) begin
      if (!head_valid_q) begin
        head_valid_d = 1'b1;
        head_pc_d    = req_pc_q;
        head_instr_d = imem_rdata;
      end else begin
        skid_valid_d = 1'b1;
        skid_pc_d    = req_pc_q;
        skid_instr_d = imem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_ADDR;
      req_pc_q     <= RESET_ADDR;
      drop_q       <= 1'b0;
      head_valid_q <= 1'b0;
      head_pc_q    <= 32'h0;
      head_instr_q <= NOP_INSTR;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      drop_q       <= drop_d;
      head_valid_q <= head_valid_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign if_valid = head_valid_q;
  assign if_pc    = head_pc_q;
  assign if_instr = head_valid_q ? head_instr_q : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_addr = 32'h0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.RESET_ADDR(RESET_ADDR), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_en(redirect_en), .redirect_addr(redirect_addr),
    .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;
  logic [63:0] exp_q[$];       // {pc, instr} in architectural fetch order
  logic [31:0] model_pc;
  logic [31:0] prev_pc = 32'h0;
  bit          saw_wrap = 1'b0;

  // memory model state
  bit          rand_mem = 1'b0;
  int          rsp_delay = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_cnt = 0;
  bit          granted_last = 1'b0;
  logic [31:0] last_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // The reference stream: after reset or a redirect, decode must see
  // consecutive words starting at the restart address.
  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({model_pc, mem_word(model_pc)});
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic model_restart(input logic [31:0] pc);
    exp_q.delete();
    model_pc = pc;
    refill();
  endtask

  // ---------------- driver tasks ----------------
  // tick: advance to just after the next edge and play the memory side.
  task automatic tick();
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (granted_last) begin
      check("single_outstanding", {31'b0, pend}, 32'd0);
      pend      = 1'b1;
      pend_addr = last_addr;
      pend_cnt  = rand_mem ? int'($urandom_range(0, 2)) : rsp_delay;
    end
    granted_last = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend        = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  // apply: decide grant for the visible request and drive core-side inputs.
  task automatic apply(input bit s, input bit r, input logic [31:0] ra);
    imem_gnt      = imem_req && (rand_mem ? ($urandom_range(0, 3) != 0) : 1'b1);
    granted_last  = imem_req && imem_gnt;
    last_addr     = imem_addr;
    stall         = s;
    redirect_en   = r;
    redirect_addr = ra;
    if (r) model_restart({ra[31:2], 2'b00});
    refill();
  endtask

  task automatic step(input bit s, input bit r, input logic [31:0] ra);
    tick();
    apply(s, r, ra);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    imem_gnt     = 1'b0;
    imem_rvalid  = 1'b0;
    stall        = 1'b0;
    redirect_en  = 1'b0;
    pend         = 1'b0;
    granted_last = 1'b0;
    model_restart(RESET_ADDR);
    n_pop = 0;
    #1;
    check({tag, "_if_valid"}, {31'b0, if_valid}, 32'd0);
    check({tag, "_imem_req"}, {31'b0, imem_req}, 32'd0);
    check({tag, "_imem_addr"}, imem_addr, RESET_ADDR);
    check({tag, "_if_pc"}, if_pc, 32'h0);
    check({tag, "_if_instr"}, if_instr, NOP);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check({tag, "_idle_req"}, {31'b0, imem_req}, 32'd0);
    apply(1'b0, 1'b0, 32'h0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (!if_valid) check("nop_when_invalid", if_instr, NOP);
      check("queue_overflow",
            {31'b0, dut.push && dut.head_valid_q && dut.skid_valid_q && !dut.consume}, 32'd0);
      // Consume happens at the coming edge; a redirect makes it irrelevant.
      if (if_valid && !stall && !redirect_en) begin
        if (exp_q.size() == 0) begin
          check("exp_q_empty", 32'd1, 32'd0);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("if_pc", if_pc, e[63:32]);
          check("if_instr", if_instr, e[31:0]);
          if (if_pc == 32'h0 && prev_pc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
          prev_pc = if_pc;
          n_pop++;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit found;

    // 1: reset, zero-wait gnt, rvalid +1
    do_reset("rst0");
    tick();
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, RESET_ADDR);
    apply(1'b0, 1'b0, 32'h0);
    repeat (12) step(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    check("throughput_pops", n_pop, 32'd6);

    // 2: stall holds head+skid, requests stop, then drain back-to-back
    do_reset("rst1");
    tick();
    apply(1'b1, 1'b0, 32'h0);
    repeat (10) step(1'b1, 1'b0, 32'h0);
    check("stall_req_gated", {31'b0, imem_req}, 32'd0);
    check("stall_head_valid", {31'b0, if_valid}, 32'd1);
    check("stall_head_pc", if_pc, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("drain_valid", {31'b0, if_valid}, 32'd1);
    check("drain_pc", if_pc, 32'h4);
    check("resume_req", {31'b0, imem_req}, 32'd1);
    check("resume_addr", imem_addr, 32'h8);
    repeat (6) step(1'b0, 1'b0, 32'h0);

    // 3: redirect while waiting for 0x8
    do_reset("rst2");
    rsp_delay = 2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (pend && pend_addr == 32'h8 && !imem_rvalid) begin
        apply(1'b0, 1'b1, 32'h100);
        found = 1'b1;
      end else begin
        apply(1'b0, 1'b0, 32'h0);
      end
    end
    check("redir_wait_found", {31'b0, found}, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (imem_req) found = 1'b1;
      else apply(1'b0, 1'b0, 32'h0);
    end
    check("redir_wait_req", {31'b0, found}, 32'd1);
    check("redir_wait_addr", imem_addr, 32'h100);
    apply(1'b0, 1'b0, 32'h0);
    repeat (10) step(1'b0, 1'b0, 32'h0);
    rsp_delay = 0;

    // 4: redirect to 0x203 coincident with grant of 0xC
    do_reset("rst3");
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (imem_req && imem_addr == 32'hC) begin
        apply(1'b0, 1'b1, 32'h203);
        found = 1'b1;
      end else begin
        apply(1'b0, 1'b0, 32'h0);
      end
    end
    check("redir_gnt_found", {31'b0, found}, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (imem_req) found = 1'b1;
      else apply(1'b0, 1'b0, 32'h0);
    end
    check("redir_gnt_req", {31'b0, found}, 32'd1);
    check("redir_gnt_addr", imem_addr, 32'h200);
    apply(1'b0, 1'b0, 32'h0);
    repeat (10) step(1'b0, 1'b0, 32'h0);

    // 5: redirect with rvalid while stalled with a valid head
    do_reset("rst4");
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (imem_rvalid && if_valid) begin
        apply(1'b1, 1'b1, 32'h300);
        found = 1'b1;
      end else begin
        apply(1'b1, 1'b0, 32'h0);
      end
    end
    check("redir_rv_found", {31'b0, found}, 32'd1);
    tick();
    check("redir_rv_valid", {31'b0, if_valid}, 32'd0);
    check("redir_rv_req", {31'b0, imem_req}, 32'd1);
    check("redir_rv_addr", imem_addr, 32'h300);
    apply(1'b0, 1'b0, 32'h0);
    repeat (10) step(1'b0, 1'b0, 32'h0);

    // 6: reset mid-WAIT with a valid head, restart, then address wrap
    do_reset("rst5");
    rsp_delay = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (pend && pend_addr == 32'h4) found = 1'b1;
      apply(1'b1, 1'b0, 32'h0);
    end
    check("mid_wait_found", {31'b0, found}, 32'd1);
    check("mid_wait_head", {31'b0, if_valid}, 32'd1);
    do_reset("rst_wait");
    rsp_delay = 0;
    tick();
    check("restart_req", {31'b0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, RESET_ADDR);
    apply(1'b0, 1'b0, 32'h0);
    repeat (6) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'hFFFF_FFFE);
    repeat (14) step(1'b0, 1'b0, 32'h0);
    check("wrap_seen", {31'b0, saw_wrap}, 32'd1);

    // 7: randomized traffic
    rand_mem = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : 32'($urandom_range(0, 32'h3FF));
      step($urandom_range(0, 9) < 3, $urandom_range(0, 29) == 0, ra);
    end
    rand_mem = 1'b0;
    repeat (20) step(1'b0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
